// File: rtl/adc_cmd_seq.sv
// Command sequencer for a SPI-attached ADC: writes config, calibrates, primes the
// result pipeline, then loops CONVERT over all channels and returns samples.
`timescale 1ns/1ps
module adc_cmd_seq #(
    parameter int NUM_CH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] cfg,
    output logic        fs,
    input  logic        fd_spi,
    input  logic        fd_prd,
    output logic [15:0] chip_txd,
    input  logic [15:0] chip_rxd,
    output logic [15:0] smp_data,
    output logic [5:0]  smp_ch,
    output logic        smp_vld,
    output logic        frame_done,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, CFG, CAL, DUMMY, CONV, FLUSH} state_t;
    typedef enum logic [1:0] {PH_LOAD, PH_SPI, PH_PRD} phase_t;

    localparam logic [5:0]  LAST_CH = 6'(NUM_CH - 1);
    localparam logic [15:0] RD63    = 16'hFF00;
    localparam logic [15:0] CAL_CMD = 16'h5500;

    function automatic logic [15:0] wr_cmd(input logic [5:0] r, input logic [7:0] d);
        return {2'b10, r, d};
    endfunction

    function automatic logic [15:0] conv_cmd(input logic [5:0] ch);
        return {2'b00, ch, 8'h00};
    endfunction

    state_t      state;
    phase_t      phase;
    logic [5:0]  cnt;
    logic [31:0] cfg_reg;
    logic        stop_pend;
    // tag_a describes the previous command, tag_b the one before it; the ADC
    // answers command n during command n+2, so tag_b owns the incoming word.
    logic        tag_a_conv, tag_b_conv;
    logic [5:0]  tag_a_ch, tag_b_ch;

    logic [1:0]  byte_sel;
    logic [7:0]  cfg_next;
    logic        stop_now;

    assign byte_sel = cnt[1:0] + 2'd1;
    assign cfg_next = cfg_reg[{byte_sel, 3'b000} +: 8];
    assign stop_now = stop_pend | stop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            phase      <= PH_LOAD;
            cnt        <= 6'd0;
            cfg_reg    <= 32'h0;
            stop_pend  <= 1'b0;
            tag_a_conv <= 1'b0;
            tag_b_conv <= 1'b0;
            tag_a_ch   <= 6'd0;
            tag_b_ch   <= 6'd0;
            fs         <= 1'b0;
            chip_txd   <= 16'h0000;
            smp_data   <= 16'h0000;
            smp_ch     <= 6'd0;
            smp_vld    <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            smp_vld    <= 1'b0;
            frame_done <= 1'b0;
            if (busy && stop)
                stop_pend <= 1'b1;

            if (state == IDLE) begin
                if (start) begin
                    state    <= CFG;
                    phase    <= PH_LOAD;
                    busy     <= 1'b1;
                    cnt      <= 6'd0;
                    cfg_reg  <= cfg;
                    chip_txd <= wr_cmd(6'd0, cfg[7:0]);
                end
            end else begin
                case (phase)
                    PH_LOAD: begin
                        fs    <= 1'b1;
                        phase <= PH_SPI;
                    end
                    PH_SPI: if (fd_spi) begin
                        fs    <= 1'b0;
                        phase <= PH_PRD;
                        if (tag_b_conv) begin
                            smp_vld    <= 1'b1;
                            smp_data   <= chip_rxd;
                            smp_ch     <= tag_b_ch;
                            frame_done <= (tag_b_ch == LAST_CH);
                        end
                        tag_b_conv <= tag_a_conv;
                        tag_b_ch   <= tag_a_ch;
                        tag_a_conv <= (state == CONV);
                        tag_a_ch   <= (state == CONV) ? cnt : 6'd0;
                    end
                    PH_PRD: if (fd_prd) begin
                        phase <= PH_LOAD;
                        case (state)
                            CFG: begin
                                if (cnt == 6'd3) begin
                                    state    <= CAL;
                                    cnt      <= 6'd0;
                                    chip_txd <= CAL_CMD;
                                end else begin
                                    cnt      <= cnt + 6'd1;
                                    chip_txd <= wr_cmd({4'd0, byte_sel}, cfg_next);
                                end
                            end
                            CAL: begin
                                state    <= DUMMY;
                                cnt      <= 6'd0;
                                chip_txd <= RD63;
                            end
                            DUMMY: begin
                                if (cnt == 6'd8) begin
                                    state    <= CONV;
                                    cnt      <= 6'd0;
                                    chip_txd <= conv_cmd(6'd0);
                                end else begin
                                    cnt      <= cnt + 6'd1;
                                    chip_txd <= RD63;
                                end
                            end
                            CONV: begin
                                if (cnt == LAST_CH) begin
                                    cnt <= 6'd0;
                                    if (stop_now) begin
                                        state    <= FLUSH;
                                        chip_txd <= RD63;
                                    end else begin
                                        chip_txd <= conv_cmd(6'd0);
                                    end
                                end else begin
                                    cnt      <= cnt + 6'd1;
                                    chip_txd <= conv_cmd(cnt + 6'd1);
                                end
                            end
                            FLUSH: begin
                                if (cnt == 6'd1) begin
                                    state     <= IDLE;
                                    busy      <= 1'b0;
                                    cnt       <= 6'd0;
                                    stop_pend <= 1'b0;
                                end else begin
                                    cnt      <= cnt + 6'd1;
                                    chip_txd <= RD63;
                                end
                            end
                            default: state <= IDLE;
                        endcase
                    end
                    default: phase <= PH_LOAD;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_cmd_seq.sv
// Bench for adc_cmd_seq: SPI/ADC responder with a two-deep result latency,
// command-list model built from the sequencing rules, and a sample scoreboard.
`timescale 1ns/1ps
module tb_adc_cmd_seq;
    localparam int NCH   = 4;
    localparam int LIMIT = 20000;
    localparam int NINIT = 14;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, stop = 1'b0, fd_spi = 1'b0, fd_prd = 1'b0;
    logic [31:0] cfg = 32'h0;
    logic [15:0] chip_rxd = 16'h0;
    logic        fs, smp_vld, frame_done, busy;
    logic [15:0] chip_txd, smp_data;
    logic [5:0]  smp_ch;

    adc_cmd_seq #(.NUM_CH(NCH)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg(cfg),
        .fs(fs), .fd_spi(fd_spi), .fd_prd(fd_prd), .chip_txd(chip_txd),
        .chip_rxd(chip_rxd), .smp_data(smp_data), .smp_ch(smp_ch),
        .smp_vld(smp_vld), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  ch;
        logic [15:0] data;
    } samp_t;

    typedef struct {
        logic [31:0] cfg;
        int          stop_k;
        int          d1;
        int          d2;
        bit          spur;
        bit          lit;
        int          exp_cmds;
        int          exp_samp;
        int          exp_fd;
    } vec_t;

    int          checks = 0, failures = 0;
    int          d1 = 40, d2 = 10;
    bit          spur = 1'b0, use_lit = 1'b0;
    int          cmd_count = 0, n_samp = 0, n_fd = 0;
    bit          stable_err = 1'b0, hold_err = 1'b0;
    logic [15:0] exp_cmds[$], got_cmds[$], hist[$];
    samp_t       expq[$], samp_log[$];
    int          samp_at[$];
    logic [15:0] last_data = 16'h0;
    logic [5:0]  last_ch = 6'd0;
    vec_t        vecs[6];
    logic [15:0] lit_cmds[16] = '{16'h8011, 16'h8122, 16'h8233, 16'h8344, 16'h5500,
                                  16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00,
                                  16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'h0000, 16'h0100};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected command stream from the sequencing rules alone.
    task automatic build_cmds(input logic [31:0] c, input int frames);
        exp_cmds.delete();
        for (int k = 0; k < 4; k++) exp_cmds.push_back({2'b10, 6'(k), c[8*k +: 8]});
        exp_cmds.push_back(16'h5500);
        repeat (9) exp_cmds.push_back(16'hFF00);
        for (int f = 0; f < frames; f++)
            for (int ch = 0; ch < NCH; ch++) exp_cmds.push_back({2'b00, 6'(ch), 8'h00});
        repeat (2) exp_cmds.push_back(16'hFF00);
    endtask

    // SPI engine + ADC: answers command n with the result of command n-2.
    initial begin : responder
        logic [15:0] cmd, resp;
        logic [5:0]  ch;
        samp_t       e;
        bit          abort;
        forever begin
            @(negedge clk);
            if (rst && fs) begin
                cmd = chip_txd;
                cmd_count++;
                got_cmds.push_back(cmd);
                hist.push_back(cmd);
                if (exp_cmds.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL cmd_extra: got %h expected no command", cmd);
                end else begin
                    chk("cmd", 32'(cmd), 32'(exp_cmds.pop_front()));
                end
                abort = 1'b0;
                for (int i = 1; i < d1 && !abort; i++) begin
                    @(negedge clk);
                    if (!rst) abort = 1'b1;
                    else if (!fs || chip_txd !== cmd) stable_err = 1'b1;
                end
                if (!abort) begin
                    resp = 16'($urandom);
                    if (hist.size() >= 3 && hist[hist.size()-3][15:14] == 2'b00) begin
                        ch = hist[hist.size()-3][13:8];
                        if (use_lit) resp = 16'hA000 + 16'(ch);
                        e.ch = ch;
                        e.data = resp;
                        expq.push_back(e);
                    end
                    chip_rxd = resp;
                    fd_spi = 1'b1;
                    @(negedge clk);
                    fd_spi = 1'b0;
                    chip_rxd = 16'($urandom);
                    if (!rst) abort = 1'b1;
                    else if (fs) stable_err = 1'b1;
                end
                for (int i = 0; i < d2 - 1 && !abort; i++) begin
                    fd_spi = spur && (i == 0);
                    @(negedge clk);
                    fd_spi = 1'b0;
                    if (!rst) abort = 1'b1;
                end
                if (!abort) begin
                    fd_prd = 1'b1;
                    @(negedge clk);
                    fd_prd = 1'b0;
                end
            end
        end
    end

    // Sample scoreboard, one line per delivered sample.
    always @(negedge clk) begin
        samp_t e;
        if (!rst) begin
            last_data = 16'h0;
            last_ch = 6'd0;
        end else begin
            if (smp_vld) begin
                n_samp++;
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL smp_unexpected: got ch=%0d data=%h expected no sample", smp_ch, smp_data);
                end else begin
                    e = expq.pop_front();
                    chk("smp_ch", 32'(smp_ch), 32'(e.ch));
                    chk("smp_data", 32'(smp_data), 32'(e.data));
                    chk("frame_done", 32'(frame_done), 32'(e.ch == 6'(NCH - 1)));
                end
                e.ch = smp_ch;
                e.data = smp_data;
                samp_log.push_back(e);
                samp_at.push_back(cmd_count);
                $display("sample ch=%0d data=%h frame_done=%0b during_cmd=%0d", smp_ch, smp_data, frame_done, cmd_count);
                last_data = smp_data;
                last_ch = smp_ch;
            end else begin
                if (frame_done) begin
                    checks++;
                    failures++;
                    $display("FAIL frame_done_orphan: got 1 expected 0 without smp_vld");
                end
                if (smp_data !== last_data || smp_ch !== last_ch) hold_err = 1'b1;
            end
            if (frame_done) n_fd++;
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        int  frames;
        bit  stopped, restarted, done;
        d1 = v.d1;
        d2 = v.d2;
        spur = v.spur;
        use_lit = v.lit;
        frames = (v.stop_k < NINIT) ? 1 : (v.stop_k - NINIT) / NCH + 1;
        build_cmds(v.cfg, frames);
        cmd_count = 0;
        n_samp = 0;
        n_fd = 0;
        samp_log.delete();
        samp_at.delete();
        got_cmds.delete();
        stable_err = 1'b0;
        hold_err = 1'b0;
        @(negedge clk);
        cfg = v.cfg;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg = $urandom;
        stopped = 1'b0;
        restarted = 1'b0;
        done = 1'b0;
        for (int t = 0; t < LIMIT && !done; t++) begin
            @(negedge clk);
            start = 1'b0;
            stop = 1'b0;
            if (spur && !restarted && cmd_count == 3) begin
                start = 1'b1;
                restarted = 1'b1;
            end
            if (!stopped && cmd_count == v.stop_k + 1) begin
                stop = 1'b1;
                stopped = 1'b1;
            end else if (stopped && !busy) begin
                done = 1'b1;
            end
        end
        start = 1'b0;
        stop = 1'b0;
        chk("run_done", 32'(done), 32'd1);
        repeat (3) @(negedge clk);
        chk("cmd_count", 32'(cmd_count), 32'(v.exp_cmds));
        chk("samp_count", 32'(n_samp), 32'(v.exp_samp));
        chk("frame_done_count", 32'(n_fd), 32'(v.exp_fd));
        chk("cmds_left", 32'(exp_cmds.size()), 32'd0);
        chk("samples_left", 32'(expq.size()), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        chk("fs_after", 32'(fs), 32'd0);
        chk("handshake_stable", 32'(stable_err), 32'd0);
        chk("smp_hold", 32'(hold_err), 32'd0);
        for (int i = 0; i < samp_at.size(); i++)
            chk("smp_latency", 32'(samp_at[i]), 32'(NINIT + 3 + i));
        if (v.lit) begin
            for (int i = 0; i < 16; i++)
                chk("lit_cmd", (i < got_cmds.size()) ? 32'(got_cmds[i]) : 32'hFFFF_FFFF, 32'(lit_cmds[i]));
            chk("lit_smp0", (samp_log.size() > 0) ? 32'(samp_log[0]) : 32'hFFFF_FFFF, 32'({6'd0, 16'hA000}));
            chk("lit_smp3", (samp_log.size() > 3) ? 32'(samp_log[3]) : 32'hFFFF_FFFF, 32'({6'd3, 16'hA003}));
        end
        $display("run %0d: cfg=%h stop_k=%0d cmds=%0d samples=%0d frame_done=%0d", idx, v.cfg, v.stop_k, cmd_count, n_samp, n_fd);
    endtask

    initial begin
        bit reached, quiet;
        vecs[0] = '{32'h44332211, 15, 40, 10, 1'b0, 1'b1, 20, 4, 1};
        vecs[1] = '{$urandom, 3, 3, 2, 1'b1, 1'b0, 20, 4, 1};
        vecs[2] = '{$urandom, 25, 5, 4, 1'b1, 1'b0, 28, 12, 3};
        vecs[3] = '{$urandom, 17, 4, 3, 1'b0, 1'b0, 20, 4, 1};
        vecs[4] = '{$urandom, 18, 3, 2, 1'b1, 1'b0, 24, 8, 2};
        vecs[5] = '{$urandom, 13, 6, 5, 1'b0, 1'b0, 20, 4, 1};

        #3 rst = 1'b0;
        #9;
        chk("rst_fs", 32'(fs), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_smp_vld", 32'(smp_vld), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_chip_txd", 32'(chip_txd), 32'd0);
        chk("rst_smp_data", 32'(smp_data), 32'd0);
        chk("rst_smp_ch", 32'(smp_ch), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Reset in the middle of a CONVERT handshake.
        d1 = 40;
        d2 = 10;
        spur = 1'b0;
        use_lit = 1'b0;
        build_cmds(32'h0BADF00D, 30);
        cmd_count = 0;
        @(negedge clk);
        cfg = 32'h0BADF00D;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reached = 1'b0;
        for (int t = 0; t < LIMIT && !reached; t++) begin
            @(negedge clk);
            if (cmd_count == 17) reached = 1'b1;
        end
        chk("rst_mid_reach", 32'(reached), 32'd1);
        repeat (5) @(negedge clk);
        chk("fs_before_rst", 32'(fs), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_fs", 32'(fs), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_smp_vld", 32'(smp_vld), 32'd0);
        chk("mid_rst_frame_done", 32'(frame_done), 32'd0);
        chk("mid_rst_chip_txd", 32'(chip_txd), 32'd0);
        chk("mid_rst_smp_data", 32'(smp_data), 32'd0);
        chk("mid_rst_smp_ch", 32'(smp_ch), 32'd0);
        repeat (3) @(negedge clk);
        exp_cmds.delete();
        expq.delete();
        hist.delete();
        rst = 1'b1;
        quiet = 1'b1;
        repeat (80) begin
            @(negedge clk);
            if (smp_vld || fs || busy) quiet = 1'b0;
        end
        chk("quiet_after_rst", 32'(quiet), 32'd1);
        $display("reset mid-handshake: outputs cleared, idle until next start");

        run_vec(vecs[0], 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
